// File: rtl/bp_be_pkg.sv
// Shared backend definitions: miss-walk FSM states and the 2-bit miss/fault type encoding.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_req   = 2'd1,
        e_wait  = 2'd2,
        e_fault = 2'd3
    } bp_be_sys_miss_state_e;

    localparam logic [1:0] e_miss_type_none  = 2'd0;
    localparam logic [1:0] e_miss_type_instr = 2'd1;
    localparam logic [1:0] e_miss_type_load  = 2'd2;
    localparam logic [1:0] e_miss_type_store = 2'd3;

    // ITLB misses take priority; a data miss is classified by the instruction kind.
    function automatic logic [1:0] miss_type(input logic itlb_miss, input logic is_store);
        if (itlb_miss)
            return e_miss_type_instr;
        return is_store ? e_miss_type_store : e_miss_type_load;
    endfunction

endpackage

// File: rtl/bp_be_sys_cmd_pipe.sv
// CSR command delay line: stages_p stages of valid/payload/is_store with per-stage kill
// and a synchronous flush that empties every stage, including the one being loaded.
module bp_be_sys_cmd_pipe #(
    parameter int stages_p    = 2,
    parameter int cmd_width_p = 128
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [cmd_width_p-1:0] cmd_i,
    input  logic                   is_store_i,
    input  logic [stages_p-1:0]    kill_i,
    input  logic                   flush_i,
    output logic                   live_o,
    output logic [cmd_width_p-1:0] cmd_o,
    output logic                   is_store_o
);

    logic [stages_p-1:0]    v_q;
    logic [stages_p-1:0]    st_q;
    logic [cmd_width_p-1:0] cmd_q [stages_p];

    // NOTE: the payload array is reset too so cmd_o reads zero straight out of reset;
    // plain storage that nothing observes before it is written could skip the reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q  <= '0;
            st_q <= '0;
            for (int k = 0; k < stages_p; k++)
                cmd_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old
            // value on the same edge; blocking ones would collapse the shift into one hop.
            v_q[0]   <= v_i & ~flush_i;
            st_q[0]  <= is_store_i;
            cmd_q[0] <= cmd_i;
            for (int k = 1; k < stages_p; k++) begin
                v_q[k]   <= v_q[k-1] & ~kill_i[k-1] & ~flush_i;
                st_q[k]  <= st_q[k-1];
                cmd_q[k] <= cmd_q[k-1];
            end
        end
    end

    assign live_o     = v_q[stages_p-1] & ~kill_i[stages_p-1];
    assign cmd_o      = cmd_q[stages_p-1];
    assign is_store_o = st_q[stages_p-1];

endmodule

// File: rtl/bp_be_sys_miss_pipe.sv
// Backend system pipe: CSR command pipeline plus final-stage TLB miss capture, a registered
// valid/ready request to the page-table walker, and the walk-tracking FSM.
module bp_be_sys_miss_pipe
    import bp_be_pkg::*;
#(
    parameter int stages_p      = 2,
    parameter int cmd_width_p   = 128,
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_v_i,
    input  logic [cmd_width_p-1:0]   cmd_i,
    input  logic                     is_store_i,
    input  logic [stages_p-1:0]      kill_i,
    input  logic                     itlb_miss_i,
    input  logic                     dtlb_miss_i,
    input  logic [vaddr_width_p-1:0] miss_pc_i,
    input  logic [vaddr_width_p-1:0] miss_vaddr_i,
    output logic                     cmd_v_o,
    output logic [cmd_width_p-1:0]   cmd_o,
    output logic                     flush_o,
    output logic                     busy_o,
    output logic                     miss_v_o,
    input  logic                     miss_ready_i,
    output logic [1:0]               miss_type_o,
    output logic [vaddr_width_p-1:0] miss_pc_o,
    output logic [vaddr_width_p-1:0] miss_vaddr_o,
    input  logic                     fill_v_i,
    input  logic                     fill_fault_i,
    output logic                     fault_v_o,
    output logic [1:0]               fault_type_o,
    output logic [vaddr_width_p-1:0] fault_pc_o,
    output logic [vaddr_width_p-1:0] fault_vaddr_o
);

    bp_be_sys_miss_state_e state_q, state_d;

    logic                     live;
    logic                     fin_is_store;
    logic                     any_miss;
    logic                     capture;
    logic                     flush_q;
    logic [1:0]               type_q;
    logic [vaddr_width_p-1:0] pc_q;
    logic [vaddr_width_p-1:0] vaddr_q;

    bp_be_sys_cmd_pipe #(
        .stages_p   (stages_p),
        .cmd_width_p(cmd_width_p)
    ) cmd_pipe (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .v_i       (cmd_v_i & ~busy_o),
        .cmd_i     (cmd_i),
        .is_store_i(is_store_i),
        .kill_i    (kill_i),
        .flush_i   (capture),
        .live_o    (live),
        .cmd_o     (cmd_o),
        .is_store_o(fin_is_store)
    );

    // A kill of the final stage clears live, so kill always wins over a miss.
    assign any_miss = itlb_miss_i | dtlb_miss_i;
    assign capture  = (state_q == e_idle) & live & any_miss;
    assign cmd_v_o  = (state_q == e_idle) & live & ~any_miss;

    // NOTE: state_d takes a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            e_idle:  if (capture)      state_d = e_req;
            e_req:   if (miss_ready_i) state_d = e_wait;
            e_wait:  if (fill_v_i)     state_d = fill_fault_i ? e_fault : e_idle;
            e_fault:                   state_d = e_idle;
            default:                   state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            flush_q <= 1'b0;
            type_q  <= e_miss_type_none;
            pc_q    <= '0;
            vaddr_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= capture;
            if (capture) begin
                type_q  <= miss_type(itlb_miss_i, fin_is_store);
                pc_q    <= miss_pc_i;
                vaddr_q <= itlb_miss_i ? miss_pc_i : miss_vaddr_i;
            end
        end
    end

    assign flush_o  = flush_q;
    assign busy_o   = (state_q != e_idle);
    assign miss_v_o = (state_q == e_req);
    assign fault_v_o = (state_q == e_fault);

    // Request and fault report share the capture latch; it only changes at a capture.
    assign miss_type_o   = type_q;
    assign miss_pc_o     = pc_q;
    assign miss_vaddr_o  = vaddr_q;
    assign fault_type_o  = type_q;
    assign fault_pc_o    = pc_q;
    assign fault_vaddr_o = vaddr_q;

endmodule

// File: tb/tb_bp_be_sys_miss_pipe.sv
// Scoreboard bench for bp_be_sys_miss_pipe (stages_p=3): a cycle-indexed schedule model
// predicts command delivery, flushes, walks and faults; a negedge monitor compares.
module tb_bp_be_sys_miss_pipe;

    localparam int S  = 3;
    localparam int CW = 128;
    localparam int VW = 39;
    localparam int N  = 1500;
    localparam int NA = N + 64;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          cmd_v_i;
    logic [CW-1:0] cmd_i;
    logic          is_store_i;
    logic [S-1:0]  kill_i;
    logic          itlb_miss_i, dtlb_miss_i;
    logic [VW-1:0] miss_pc_i, miss_vaddr_i;
    logic          cmd_v_o;
    logic [CW-1:0] cmd_o;
    logic          flush_o, busy_o, miss_v_o, miss_ready_i;
    logic [1:0]    miss_type_o, fault_type_o;
    logic [VW-1:0] miss_pc_o, miss_vaddr_o, fault_pc_o, fault_vaddr_o;
    logic          fill_v_i, fill_fault_i, fault_v_o;

    always #5 clk = ~clk;

    bp_be_sys_miss_pipe #(.stages_p(S), .cmd_width_p(CW), .vaddr_width_p(VW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_i(cmd_i), .is_store_i(is_store_i), .kill_i(kill_i),
        .itlb_miss_i(itlb_miss_i), .dtlb_miss_i(dtlb_miss_i),
        .miss_pc_i(miss_pc_i), .miss_vaddr_i(miss_vaddr_i),
        .cmd_v_o(cmd_v_o), .cmd_o(cmd_o), .flush_o(flush_o), .busy_o(busy_o),
        .miss_v_o(miss_v_o), .miss_ready_i(miss_ready_i), .miss_type_o(miss_type_o),
        .miss_pc_o(miss_pc_o), .miss_vaddr_o(miss_vaddr_o),
        .fill_v_i(fill_v_i), .fill_fault_i(fill_fault_i),
        .fault_v_o(fault_v_o), .fault_type_o(fault_type_o),
        .fault_pc_o(fault_pc_o), .fault_vaddr_o(fault_vaddr_o)
    );

    int errors = 0;
    int checks = 0;
    int cur    = 0;
    bit run    = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cur, act, exp);
        end
    endtask

    typedef struct { int cyc; logic [CW-1:0] data; } cmd_exp_t;
    typedef struct { logic [1:0] typ; logic [VW-1:0] pc; logic [VW-1:0] va; } miss_exp_t;

    cmd_exp_t  exp_cmd[$];
    miss_exp_t exp_miss[$];
    miss_exp_t exp_fault[$];

    // Per-cycle schedule: issued commands, forced input values and expected status flags.
    bit            cmd_v_at[NA];
    logic [CW-1:0] cmd_d_at[NA];
    bit            cmd_st_at[NA];
    int            kill_at[NA];
    bit            cap_at[NA];
    bit            busy_m[NA], flush_m[NA], req_m[NA], fault_m[NA];
    bit            miss_f[NA], itlb_at[NA], dtlb_at[NA];
    logic [VW-1:0] pc_at[NA], va_at[NA];
    bit            rdy_f[NA], rdy_at[NA], fill_f[NA], fill_at[NA], flt_at[NA];

    function automatic logic [CW-1:0] rand_cmd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [VW-1:0] rand_va();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[VW-1:0];
    endfunction

    // Command issued in cycle t sits in stage k during cycle t+1+k and is offered at t+S.
    // A capture in cycle m flushes everything in flight and keeps the walker busy after it.
    task automatic plan_cmd(input int t, input logic [CW-1:0] data, input int ks, input int mk,
                            input bit st, input logic [VW-1:0] pc, input logic [VW-1:0] va,
                            input int r, input int w, input bit flt, input bit spur);
        int        m;
        bit        flushed;
        bit        itlb;
        logic [1:0] typ;
        miss_exp_t me;
        cmd_exp_t  ce;
        cmd_v_at[t]  = 1'b1;
        cmd_d_at[t]  = data;
        cmd_st_at[t] = st;
        kill_at[t]   = ks;
        flushed = 1'b0;
        for (int i = 1; i <= S; i++)
            if (t - i >= 0 && cap_at[t-i]) flushed = 1'b1;
        if (busy_m[t] || flushed || ks == 0 || ks == 1)
            return;
        m = t + S;
        miss_f[m]  = 1'b1;
        itlb_at[m] = (mk == 1 || mk == 3);
        dtlb_at[m] = (mk == 2 || mk == 3);
        pc_at[m]   = pc;
        va_at[m]   = va;
        if (ks == 2)
            return;
        if (mk == 0) begin
            ce.cyc = m;
            ce.data = data;
            exp_cmd.push_back(ce);
            return;
        end
        cap_at[t] = 1'b1;
        itlb = itlb_at[m];
        typ  = itlb ? 2'd1 : (st ? 2'd3 : 2'd2);
        me.typ = typ;
        me.pc  = pc;
        me.va  = itlb ? pc : va;
        exp_miss.push_back(me);
        flush_m[m+1] = 1'b1;
        for (int i = 1; i <= r; i++) begin
            req_m[m+i]  = 1'b1;
            busy_m[m+i] = 1'b1;
            rdy_f[m+i]  = 1'b1;
            rdy_at[m+i] = (i == r);
        end
        if (spur) begin
            fill_f[m+r]  = 1'b1;
            fill_at[m+r] = 1'b1;
            flt_at[m+r]  = 1'($urandom_range(0, 1));
        end
        for (int i = 1; i <= w; i++) begin
            busy_m[m+r+i]  = 1'b1;
            fill_f[m+r+i]  = 1'b1;
            fill_at[m+r+i] = (i == w);
            flt_at[m+r+i]  = flt;
        end
        if (flt) begin
            busy_m[m+r+w+1]  = 1'b1;
            fault_m[m+r+w+1] = 1'b1;
            exp_fault.push_back(me);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        cmd_exp_t  ce;
        miss_exp_t me;
        if (run) begin
            check("busy_o", busy_o, busy_m[cur]);
            check("flush_o", flush_o, flush_m[cur]);
            check("miss_v_o", miss_v_o, req_m[cur]);
            check("fault_v_o", fault_v_o, fault_m[cur]);
            while (exp_cmd.size() > 0 && exp_cmd[0].cyc < cur) begin
                checks++;
                errors++;
                $display("FAIL cmd_missing at cycle %0d: got no cmd_v_o, expected one at cycle %0d",
                         cur, exp_cmd[0].cyc);
                void'(exp_cmd.pop_front());
            end
            if (cmd_v_o) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_spurious", 1'b1, 1'b0);
                end else begin
                    ce = exp_cmd.pop_front();
                    check("cmd_cycle", cur, ce.cyc);
                    check("cmd_data", cmd_o, ce.data);
                end
            end
            if (miss_v_o && exp_miss.size() > 0) begin
                me = exp_miss[0];
                check("miss_type", miss_type_o, me.typ);
                check("miss_pc", miss_pc_o, me.pc);
                check("miss_vaddr", miss_vaddr_o, me.va);
                if (miss_ready_i)
                    void'(exp_miss.pop_front());
            end
            if (fault_v_o && exp_fault.size() > 0) begin
                me = exp_fault.pop_front();
                check("fault_type", fault_type_o, me.typ);
                check("fault_pc", fault_pc_o, me.pc);
                check("fault_vaddr", fault_vaddr_o, me.va);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_flush"}, flush_o, 1'b0);
        check({tag, "_miss_v"}, miss_v_o, 1'b0);
        check({tag, "_fault_v"}, fault_v_o, 1'b0);
        check({tag, "_cmd_v"}, cmd_v_o, 1'b0);
        check({tag, "_cmd_o"}, cmd_o, '0);
        check({tag, "_miss_type"}, miss_type_o, 2'd0);
        check({tag, "_miss_pc"}, miss_pc_o, '0);
        check({tag, "_miss_vaddr"}, miss_vaddr_o, '0);
        check({tag, "_fault_pc"}, fault_pc_o, '0);
    endtask

    task automatic quiet_inputs();
        cmd_v_i = 1'b0; cmd_i = '0; is_store_i = 1'b0; kill_i = '0;
        itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0; miss_pc_i = '0; miss_vaddr_i = '0;
        miss_ready_i = 1'b0; fill_v_i = 1'b0; fill_fault_i = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] q;
        bit go;
        int ks, mk;
        reset_i = 1'b1;
        quiet_inputs();
        #3;
        check_all_zero("reset");
        #9;
        reset_i = 1'b0;
        run = 1'b1;

        for (int c = 0; c < N; c++) begin
            step();
            cur = c;
            if (c == 5)
                plan_cmd(c, rand_cmd(), -1, 0, 1'b0, rand_va(), rand_va(), 1, 1, 1'b0, 1'b0);
            else if (c == 10)
                plan_cmd(c, rand_cmd(), 1, 0, 1'b0, rand_va(), rand_va(), 1, 1, 1'b0, 1'b0);
            else if (c == 11)
                plan_cmd(c, rand_cmd(), -1, 0, 1'b0, rand_va(), rand_va(), 1, 1, 1'b0, 1'b0);
            else if (c == 20)
                plan_cmd(c, rand_cmd(), -1, 2, 1'b1, 39'h1234, 39'h4000, 4, 2, 1'b1, 1'b0);
            else if (c == 40)
                plan_cmd(c, rand_cmd(), -1, 3, 1'b0, 39'h8000, 39'h123, 1, 1, 1'b0, 1'b1);
            else if (c == 50)
                plan_cmd(c, rand_cmd(), 2, 2, 1'b0, rand_va(), rand_va(), 1, 1, 1'b0, 1'b0);
            else if (c >= 60 && c < N - 24) begin
                go = busy_m[c] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                if (go) begin
                    ks = int'($urandom_range(0, 9));
                    if (ks > 2) ks = -1;
                    mk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
                    plan_cmd(c, rand_cmd(), ks, mk, 1'($urandom_range(0, 1)), rand_va(), rand_va(),
                             int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            cmd_v_i    = cmd_v_at[c];
            cmd_i      = cmd_v_at[c] ? cmd_d_at[c] : rand_cmd();
            is_store_i = cmd_v_at[c] ? cmd_st_at[c] : 1'($urandom_range(0, 1));
            for (int k = 0; k < S; k++)
                kill_i[k] = (c - 1 - k >= 0) && cmd_v_at[c-1-k] && (kill_at[c-1-k] == k);
            if (miss_f[c]) begin
                itlb_miss_i  = itlb_at[c];
                dtlb_miss_i  = dtlb_at[c];
                miss_pc_i    = pc_at[c];
                miss_vaddr_i = va_at[c];
            end else begin
                itlb_miss_i  = ($urandom_range(0, 3) == 0);
                dtlb_miss_i  = ($urandom_range(0, 3) == 0);
                miss_pc_i    = rand_va();
                miss_vaddr_i = rand_va();
            end
            miss_ready_i = rdy_f[c] ? rdy_at[c] : 1'($urandom_range(0, 1));
            fill_v_i     = fill_f[c] ? fill_at[c] : ($urandom_range(0, 3) == 0);
            fill_fault_i = fill_f[c] ? flt_at[c] : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        run = 1'b0;
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("miss_queue_drained", exp_miss.size(), 0);
        check("fault_queue_drained", exp_fault.size(), 0);
        quiet_inputs();

        // Asynchronous reset in the middle of a walk, then one command through the clean pipe.
        step();
        cmd_v_i = 1'b1;
        cmd_i   = rand_cmd();
        step();
        cmd_v_i = 1'b0;
        step();
        step();
        dtlb_miss_i  = 1'b1;
        miss_vaddr_i = 39'h4000;
        step();
        dtlb_miss_i  = 1'b0;
        check("rst_seq_req_busy", busy_o, 1'b1);
        check("rst_seq_req_miss_v", miss_v_o, 1'b1);
        miss_ready_i = 1'b1;
        step();
        miss_ready_i = 1'b0;
        check("rst_seq_wait_busy", busy_o, 1'b1);
        check("rst_seq_wait_miss_v", miss_v_o, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check_all_zero("midwalk_reset");
        step();
        step();
        reset_i = 1'b0;
        step();
        q = rand_cmd();
        cmd_v_i = 1'b1;
        cmd_i   = q;
        step();
        cmd_v_i = 1'b0;
        cmd_i   = '0;
        check("post_reset_lat1", cmd_v_o, 1'b0);
        step();
        check("post_reset_lat2", cmd_v_o, 1'b0);
        step();
        check("post_reset_lat3_v", cmd_v_o, 1'b1);
        check("post_reset_lat3_data", cmd_o, q);
        check("post_reset_busy", busy_o, 1'b0);
        step();
        check("post_reset_lat4", cmd_v_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
